// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - pipeline control sequencer (IDLE/RUN/DRAIN/HALTED)
//
// Purpose: sequences a 5-stage pipeline. It starts execution and resolves
// branch, load-use, jump/return and halt events in RUN. After a halt it
// drains EX/MEM/WB for DRAIN_CYCLES cycles (legal range 1-15) and then parks
// in HALTED until reset.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start            leave IDLE
//   halt/jmp/ret     ID-stage decode events
//   branchTaken      EX-stage branch resolution
//   ID_EXE_MemRd/_rd load in EX and its destination register
//   IF_ID_rs/_rt     ID source registers; usesRt qualifies rt
//   PCWr, IF_ID_Wr   PC and IF/ID load enables
//   flush, bubble    IF/ID clear and ID/EX control zeroing
//   pcSel            00 PC+1, 01 branch, 10 jump, 11 stack top
//   running, halted  status (RUN/DRAIN, HALTED)
//   stallCnt         saturating count of load-use stall cycles
module pipeline_sequencer #(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       halt,
   input  logic       jmp,
   input  logic       ret,
   input  logic       branchTaken,
   input  logic       ID_EXE_MemRd,
   input  logic [2:0] ID_EXE_rd,
   input  logic [2:0] IF_ID_rs,
   input  logic [2:0] IF_ID_rt,
   input  logic       usesRt,
   output logic       PCWr,
   output logic       IF_ID_Wr,
   output logic       flush,
   output logic       bubble,
   output logic [1:0] pcSel,
   output logic       running,
   output logic       halted,
   output logic [7:0] stallCnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   state_t     state_q, state_d;
   logic [3:0] drain_q, drain_d;
   logic [7:0] stall_q, stall_d;
   logic       load_use;

   // Register 0 is deliberately not exempt: a load to r0 still stalls.
   assign load_use = ID_EXE_MemRd &&
                     ((ID_EXE_rd == IF_ID_rs) || (usesRt && (ID_EXE_rd == IF_ID_rt)));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         drain_q <= 4'd0;
         stall_q <= 8'd0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         stall_q <= stall_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      stall_d = stall_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            // A taken branch squashes everything decoded behind it.
            if (branchTaken) begin
               state_d = S_RUN;
            end else if (load_use) begin
               if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
            end else if (jmp || ret) begin
               state_d = S_RUN;
            end else if (halt) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         S_DRAIN: begin
            drain_d = drain_q - 4'd1;
            if (drain_q == 4'd1) state_d = S_HALTED;
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic (Mealy in RUN, pure state decode elsewhere)
   always_comb begin
      PCWr     = 1'b0;
      IF_ID_Wr = 1'b0;
      flush    = 1'b1;
      bubble   = 1'b1;
      pcSel    = 2'b00;
      running  = 1'b0;
      halted   = 1'b0;
      case (state_q)
         S_RUN: begin
            running = 1'b1;
            if (branchTaken) begin
               pcSel    = 2'b01;
               PCWr     = 1'b1;
               IF_ID_Wr = 1'b1;
            end else if (load_use) begin
               flush = 1'b0;
            end else if (jmp || ret) begin
               // ret wins the encoding when both are decoded together.
               pcSel    = ret ? 2'b11 : 2'b10;
               PCWr     = 1'b1;
               IF_ID_Wr = 1'b1;
               bubble   = 1'b0;
            end else if (!halt) begin
               PCWr     = 1'b1;
               IF_ID_Wr = 1'b1;
               flush    = 1'b0;
               bubble   = 1'b0;
            end
         end
         S_DRAIN: begin
            running = 1'b1;
         end
         S_HALTED: begin
            halted = 1'b1;
         end
         default: begin
            running = 1'b0;
         end
      endcase
   end

   assign stallCnt = stall_q;

endmodule
